// File: rtl/fetch_unit.sv
// fetch_unit: E32 instruction fetch stage with a PC-tagged prefetch FIFO and redirect flush.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the consumer when the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_data_i,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int          PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W      = PTR_W + 1;
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fifo_data_q [DEPTH];
    logic [31:0]      fifo_data_d [DEPTH];
    logic [31:0]      fifo_pc_q   [DEPTH];
    logic [31:0]      fifo_pc_d   [DEPTH];

    logic fifo_empty;
    logic resp_valid;
    logic credit_ok;
    logic issue;
    logic push;
    logic pop;

    // A read is only issued when a FIFO slot is already reserved for its response.
    always_comb begin
        fifo_empty = (count_q == '0);
        resp_valid = inflight_q && !redirect;
        credit_ok  = (count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH);
        issue      = reset && enable && !redirect && credit_ok;
        pop        = !fifo_empty && instr_ready && !redirect;
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass      = fifo_empty && resp_valid;
        push        = resp_valid && !(bypass && instr_ready);
        instr_valid = !fifo_empty || bypass;
        instr       = bypass ? mem_data_i    : fifo_data_q[rd_ptr_q];
        instr_pc    = bypass ? inflight_pc_q : fifo_pc_q[rd_ptr_q];
    end
`else
    always_comb begin
        push        = resp_valid;
        instr_valid = !fifo_empty;
        instr       = fifo_data_q[rd_ptr_q];
        instr_pc    = fifo_pc_q[rd_ptr_q];
    end
`endif

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fifo_data_d   = fifo_data_q;
        fifo_pc_d     = fifo_pc_q;

        // Flushing by snapping the write pointer keeps the old head visible as a don't-care.
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            inflight_d = 1'b0;
            wr_ptr_d   = rd_ptr_q;
            count_d    = '0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                fifo_data_d[wr_ptr_q] = mem_data_i;
                fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC_W;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fifo_data_q   <= '{default: '0};
            fifo_pc_q     <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fifo_data_q   <= fifo_data_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

    assign mem_addr = fetch_pc_q;
    assign mem_read = issue;

    // Credits reserve a slot for every outstanding read, so a push can never meet a full FIFO.
    assert property (@(posedge clk) disable iff (!reset) !(push && (count_q == CNT_W'(DEPTH))));

endmodule
